// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter_pkg: shared types and constants for the QSPI pad arbiter
package spi_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_e;
  localparam int SEL_FLASH = 0;
  localparam int SEL_RAM_A = 1;
  localparam int SEL_RAM_B = 2;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_IDLE = '1;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester-side virtual SPI bundles plus the shared pad signals
interface spi_bus_arbiter_if
  import spi_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [4*N_REQ-1:0] req_spi_data_out;
  logic [4*N_REQ-1:0] req_spi_data_oe;
  logic [N_REQ-1:0] req_spi_clk_out;
  logic [SEL_W*N_REQ-1:0] req_spi_sel;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;
  logic spi_clk_out;
  logic spi_flash_select;
  logic spi_ram_a_select;
  logic spi_ram_b_select;
  logic arb_timeout;
  modport master (
    input req, req_spi_data_out, req_spi_data_oe, req_spi_clk_out, req_spi_sel,
    output gnt, spi_data_out, spi_data_oe, spi_clk_out,
    output spi_flash_select, spi_ram_a_select, spi_ram_b_select, arb_timeout
  );
  modport slave (
    output req, req_spi_data_out, req_spi_data_oe, req_spi_clk_out, req_spi_sel, spi_data_in,
    input gnt, spi_data_out, spi_data_oe, spi_clk_out,
    input spi_flash_select, spi_ram_a_select, spi_ram_b_select, arb_timeout
  );
endinterface

// File: rtl/spi_bus_arbiter_rr_pick.sv
// spi_bus_arbiter_rr_pick: combinational round-robin picker, first request at or after ptr
module spi_bus_arbiter_rr_pick
  import spi_bus_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] winner_o
);
  // scan from the far end so the closest request to ptr is written last
  always_comb begin
    valid_o = 1'b0;
    winner_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        valid_o = 1'b1;
        winner_o = W'((int'(ptr_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of the shared QSPI pads with enforced deselect gap
// Optional tenure watchdog enabled by defining SPI_ARB_WATCHDOG_EN.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clock_i,
  input logic reset_ni,
  spi_bus_arbiter_if.master bus
);
  localparam int W = idx_w(N_REQ);
  localparam int GW = idx_w(GAP_CYCLES);
  arb_state_e state_q, state_d;
  logic [W-1:0] owner_q, owner_d, ptr_q, ptr_d, win;
  logic [N_REQ-1:0] gnt_q, gnt_d, cand;
  logic [GW-1:0] gap_q, gap_d;
  logic [SEL_W-1:0] sel;
  logic valid, own_req, expire, tout_q, act;
  assign own_req = bus.req[owner_q];
`ifdef SPI_ARB_WATCHDOG_EN
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  logic [TW-1:0] ten_q, ten_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  assign expire = state_q == GRANT && own_req && ten_q == TW'(TIMEOUT_CYCLES - 1);
  assign ten_d = state_q == GRANT ? ten_q + 1'b1 : '0;
  // a revoked owner stays out of arbitration until it drops req once
  assign mask_d = (mask_q & bus.req) | (expire ? gnt_q : '0);
  assign cand = bus.req & ~mask_q;
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      ten_q <= '0;
      mask_q <= '0;
    end else begin
      ten_q <= ten_d;
      mask_q <= mask_d;
    end
  end
`else
  assign expire = 1'b0;
  assign cand = bus.req;
`endif
  spi_bus_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .req_i(cand),
    .ptr_i(ptr_q),
    .valid_o(valid),
    .winner_o(win)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = GRANT;
        owner_d = win;
        gnt_d = N_REQ'(1) << win;
        ptr_d = win == W'(N_REQ - 1) ? '0 : win + 1'b1;
      end
      GRANT: if (!own_req || expire) begin
        gnt_d = '0;
        state_d = GAP_CYCLES == 0 ? IDLE : GAP;
        gap_d = GW'(GAP_CYCLES - 1);
      end
      GAP: begin
        state_d = gap_q == '0 ? IDLE : GAP;
        gap_d = gap_q == '0 ? '0 : gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      gnt_q <= '0;
      gap_q <= '0;
      tout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      gap_q <= gap_d;
      tout_q <= expire;
    end
  end
  assign act = state_q == GRANT;
  assign sel = act ? bus.req_spi_sel[owner_q*SEL_W +: SEL_W] : SEL_IDLE;
  assign bus.spi_data_out = act ? bus.req_spi_data_out[owner_q*4 +: 4] : '0;
  assign bus.spi_data_oe = act ? bus.req_spi_data_oe[owner_q*4 +: 4] : '0;
  assign bus.spi_clk_out = act & bus.req_spi_clk_out[owner_q];
  assign bus.spi_flash_select = sel[SEL_FLASH];
  assign bus.spi_ram_a_select = sel[SEL_RAM_A];
  assign bus.spi_ram_b_select = sel[SEL_RAM_B];
  assign bus.gnt = gnt_q;
  assign bus.arb_timeout = tout_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed bench for the QSPI pad arbiter (GAP=2 and GAP=0 instances)
module tb_spi_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2:0] sels;
  always #5 clk = ~clk;
  spi_bus_arbiter_if #(.N_REQ(2)) bus ();
  spi_bus_arbiter_if #(.N_REQ(2)) bus0 ();
  spi_bus_arbiter #(.N_REQ(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clock_i(clk), .reset_ni(rst_n), .bus(bus)
  );
  spi_bus_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut0 (
    .clock_i(clk), .reset_ni(rst_n), .bus(bus0)
  );
  assign sels = {bus.spi_ram_b_select, bus.spi_ram_a_select, bus.spi_flash_select};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req = 2'b11;
    bus0.req = 2'b11;
    step();
    step();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", bus.gnt); end
    checks++; if (bus0.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt0 got %b want 00", bus0.gnt); end
    checks++; if (sels !== 3'b111) begin errors++; $display("FAIL reset_sel got %b want 111", sels); end
    checks++; if ({bus.spi_data_oe, bus.spi_data_out, bus.spi_clk_out} !== 9'd0) begin
      errors++; $display("FAIL reset_pads got %h want 000", {bus.spi_data_oe, bus.spi_data_out, bus.spi_clk_out}); end
    checks++; if (bus.arb_timeout !== 1'b0) begin errors++; $display("FAIL reset_tout got %b want 0", bus.arb_timeout); end
    bus.req = 2'b00;
    bus0.req = 2'b00;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single;
    bus.req = 2'b01;
    step();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", bus.gnt); end
    checks++; if (bus.spi_data_out !== 4'hA) begin errors++; $display("FAIL single_dout got %h want a", bus.spi_data_out); end
    checks++; if (bus.spi_data_oe !== 4'hF) begin errors++; $display("FAIL single_oe got %h want f", bus.spi_data_oe); end
    checks++; if (sels !== 3'b110) begin errors++; $display("FAIL single_sel got %b want 110", sels); end
    bus.req_spi_clk_out[0] = 1'b1;
    #1;
    checks++; if (bus.spi_clk_out !== 1'b1) begin errors++; $display("FAIL single_clk_hi got %b want 1", bus.spi_clk_out); end
    step();
    bus.req_spi_clk_out[0] = 1'b0;
    #1;
    checks++; if (bus.spi_clk_out !== 1'b0) begin errors++; $display("FAIL single_clk_lo got %b want 0", bus.spi_clk_out); end
    step();
    bus.req = 2'b00;
    step();
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL release_gnt cyc %0d got %b want 00", c, bus.gnt); end
      checks++; if ({sels, bus.spi_data_oe} !== 7'b1110000) begin
        errors++; $display("FAIL release_pads cyc %0d got %b want 1110000", c, {sels, bus.spi_data_oe}); end
      step();
    end
    step();
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp [3];
    exp[0] = 2'b01;
    exp[1] = 2'b10;
    exp[2] = 2'b01;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req = 2'b11;
    step();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (bus.gnt !== exp[k]) begin errors++; $display("FAIL rr_gnt t%0d c%0d got %b want %b", k, c, bus.gnt, exp[k]); end
        checks++; if (sels !== (exp[k][0] ? 3'b110 : 3'b101)) begin
          errors++; $display("FAIL rr_sel t%0d c%0d got %b want %b", k, c, sels, exp[k][0] ? 3'b110 : 3'b101); end
        if (c < 3) step();
      end
      if (k < 2) begin
        bus.req = ~exp[k];
        step();
        bus.req = 2'b11;
        for (int g = 0; g < 3; g++) begin
          checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rr_gap t%0d g%0d got %b want 00", k, g, bus.gnt); end
          step();
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0;
    step();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL midrst_gnt got %b want 00", bus.gnt); end
    checks++; if ({sels, bus.spi_data_oe, bus.spi_clk_out} !== 8'b11100000) begin
      errors++; $display("FAIL midrst_pads got %b want 11100000", {sels, bus.spi_data_oe, bus.spi_clk_out}); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL midrst_regrant got %b want 01", bus.gnt); end
    bus.req = 2'b00;
    repeat (4) step();
  endtask

`ifdef SPI_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    bus.req = 2'b01;
    step();
    for (int c = 0; c < 8; c++) begin
      checks++; if ({bus.gnt, bus.arb_timeout} !== 3'b010) begin
        errors++; $display("FAIL wd_tenure c%0d got %b want 010", c, {bus.gnt, bus.arb_timeout}); end
      step();
    end
    checks++; if ({bus.gnt, bus.arb_timeout} !== 3'b001) begin errors++; $display("FAIL wd_revoke got %b want 001", {bus.gnt, bus.arb_timeout}); end
    bus.req = 2'b11;
    step();
    checks++; if ({bus.gnt, bus.arb_timeout} !== 3'b000) begin errors++; $display("FAIL wd_pulse got %b want 000", {bus.gnt, bus.arb_timeout}); end
    step();
    step();
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL wd_other got %b want 10", bus.gnt); end
    bus.req = 2'b01;
    repeat (4) step();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL wd_masked got %b want 00", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL wd_masked2 got %b want 00", bus.gnt); end
    bus.req = 2'b00;
    step();
    bus.req = 2'b01;
    step();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL wd_regrant got %b want 01", bus.gnt); end
    bus.req = 2'b00;
    repeat (4) step();
  endtask
`else
  task automatic test_watchdog;
    bus.req = 2'b01;
    step();
    for (int c = 0; c < 12; c++) begin
      checks++; if ({bus.gnt, bus.arb_timeout} !== 3'b010) begin
        errors++; $display("FAIL long_tenure c%0d got %b want 010", c, {bus.gnt, bus.arb_timeout}); end
      step();
    end
    bus.req = 2'b00;
    repeat (4) step();
  endtask
`endif

  task automatic test_gap0;
    for (int p = 0; p < 2; p++) begin
      bus0.req = 2'b01;
      step();
      for (int c = 0; c < 3; c++) begin
        checks++; if (bus0.gnt !== 2'b01) begin errors++; $display("FAIL gap0_gnt p%0d c%0d got %b want 01", p, c, bus0.gnt); end
        if (c < 2) step();
      end
      bus0.req = 2'b00;
      step();
      checks++; if (bus0.gnt !== 2'b00) begin errors++; $display("FAIL gap0_idle p%0d got %b want 00", p, bus0.gnt); end
    end
  endtask

  initial begin
    bus.req = 2'b00;
    bus.req_spi_data_out = {4'h5, 4'hA};
    bus.req_spi_data_oe = {4'h3, 4'hF};
    bus.req_spi_clk_out = 2'b00;
    bus.req_spi_sel = {3'b101, 3'b110};
    bus.spi_data_in = 4'h0;
    bus0.req = 2'b00;
    bus0.req_spi_data_out = '0;
    bus0.req_spi_data_oe = '0;
    bus0.req_spi_clk_out = '0;
    bus0.req_spi_sel = '1;
    bus0.spi_data_in = 4'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
